// File: rtl/gf_maxsum_pkg.sv
// Shared types and helpers for the GF(p) max-sum convolution block.
package gf_maxsum_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      COMP = 2'd1,
      DONE = 2'd2
   } state_t;

   // (k - s) mod field for 0 <= k, s < field, without a divider
   function automatic int mod_sub(input int k, input int s, input int field);
      int d;
      d = k - s;
      if (d < 0) d = d + field;
      return d;
   endfunction

   // Clamp to the signed llr_bit range, or keep the low llr_bit bits (sign-extended)
   function automatic int sat_trunc(input int value, input bit saturate, input int llr_bit);
      int lo;
      int hi;
      int w;
      lo = -(1 << (llr_bit - 1));
      hi = (1 << (llr_bit - 1)) - 1;
      if (saturate) begin
         if (value < lo) return lo;
         if (value > hi) return hi;
         return value;
      end
      w = value & ((1 << llr_bit) - 1);
      if (w > hi) w = w - (1 << llr_bit);
      return w;
   endfunction

endpackage

// File: rtl/llr_norm_sat.sv
// Normalises one accumulator against entry 0 and maps it back to LLR_BIT.
module llr_norm_sat
   import gf_maxsum_pkg::*;
#(
   parameter int LLR_BIT  = 4,
   parameter bit SATURATE = 1'b1
) (
   input  logic signed [LLR_BIT:0]   acc_k,
   input  logic signed [LLR_BIT:0]   acc_0,
   output logic signed [LLR_BIT-1:0] norm
);

   logic signed [LLR_BIT+1:0] diff;

   // two extra bits hold any difference of two LLR_BIT+1 values exactly
   assign diff = {acc_k[LLR_BIT], acc_k} - {acc_0[LLR_BIT], acc_0};

   // clamp or wrap into the output width
   assign norm = LLR_BIT'(sat_trunc(int'(diff), SATURATE, LLR_BIT));

endmodule

// File: rtl/gf_maxsum_conv.sv
// Sequential max-sum convolution over GF(FIELD): one shift step per cycle,
// FIELD accumulators in parallel, result normalised to entry 0.
//
// state | meaning
// IDLE  | waiting for an input pair, in_ready high
// COMP  | step s = 0..FIELD-1, acc[k] = max(acc[k], A[s] + B[(k-s) mod FIELD])
// DONE  | result held on output_llr until out_ready
module gf_maxsum_conv
   import gf_maxsum_pkg::*;
#(
   parameter int FIELD    = 3,
   parameter int LLR_BIT  = 4,
   parameter bit SATURATE = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [FIELD*LLR_BIT-1:0]   llra,
   input  logic [FIELD*LLR_BIT-1:0]   llrb,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [FIELD*LLR_BIT-1:0]   output_llr
);

   localparam int            SW     = (FIELD > 1) ? $clog2(FIELD) : 1;
   localparam int            AW     = LLR_BIT + 1;
   localparam logic [SW-1:0] S_LAST = SW'(FIELD - 1);

   state_t                    state_q, state_d;
   logic [SW-1:0]             s_q;
   logic signed [LLR_BIT-1:0] a_q   [FIELD];
   logic signed [LLR_BIT-1:0] b_q   [FIELD];
   logic signed [AW-1:0]      acc_q [FIELD];
   logic signed [AW-1:0]      acc_d [FIELD];
   logic signed [AW-1:0]      cand  [FIELD];
   logic [SW-1:0]             b_idx [FIELD];
   logic signed [LLR_BIT-1:0] norm  [FIELD];
   logic signed [LLR_BIT-1:0] a_sel;
   logic [FIELD*LLR_BIT-1:0]  out_q;
   logic                      accept;
   logic                      step_last;

   // a new pair can be taken in DONE as soon as downstream takes the result
   assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept     = in_valid && in_ready;
   assign out_valid  = (state_q == DONE);
   assign output_llr = out_q;
   assign step_last  = (s_q == S_LAST);
   assign a_sel      = a_q[s_q];

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = COMP;
         COMP:    if (step_last) state_d = DONE;
         DONE:    if (out_ready) state_d = accept ? COMP : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // candidate sums for this step and running maximum; step 0 loads directly
   always_comb begin
      for (int k = 0; k < FIELD; k++) begin
         b_idx[k] = SW'(mod_sub(k, int'(s_q), FIELD));
         cand[k]  = {a_sel[LLR_BIT-1], a_sel} + {b_q[b_idx[k]][LLR_BIT-1], b_q[b_idx[k]]};
         acc_d[k] = ((s_q == '0) || (cand[k] > acc_q[k])) ? cand[k] : acc_q[k];
      end
   end

   // normalisation works on the post-step accumulators so the last step is included
   for (genvar k = 0; k < FIELD; k++) begin : g_norm
      llr_norm_sat #(
         .LLR_BIT  (LLR_BIT),
         .SATURATE (SATURATE)
      ) u_norm (
         .acc_k (acc_d[k]),
         .acc_0 (acc_d[0]),
         .norm  (norm[k])
      );
   end

   // operand capture, step counter, accumulators and result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q   <= '0;
         out_q <= '0;
         for (int i = 0; i < FIELD; i++) begin
            a_q[i]   <= '0;
            b_q[i]   <= '0;
            acc_q[i] <= '0;
         end
      end else if (accept) begin
         s_q <= '0;
         for (int i = 0; i < FIELD; i++) begin
            a_q[i] <= llra[i*LLR_BIT +: LLR_BIT];
            b_q[i] <= llrb[i*LLR_BIT +: LLR_BIT];
         end
      end else if (state_q == COMP) begin
         s_q <= step_last ? '0 : s_q + 1'b1;
         for (int i = 0; i < FIELD; i++) acc_q[i] <= acc_d[i];
         if (step_last) begin
            for (int i = 0; i < FIELD; i++) out_q[i*LLR_BIT +: LLR_BIT] <= norm[i];
         end
      end
   end

endmodule

// File: tb/tb_gf_maxsum_conv.sv
// Bench for gf_maxsum_conv: GF(3) saturate + wrap instances in lockstep, GF(5) and GF(7).
module tb_gf_maxsum_conv;

   localparam int LB = 4;
   localparam int MW = 28;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [MW-1:0] llra, llrb;
   logic          in_valid  [3];
   logic          out_ready [3];
   logic          in_ready  [4];
   logic          out_valid [4];
   logic [11:0]   o0, o1;
   logic [19:0]   o2;
   logic [27:0]   o3;

   int n_cmp = 0;
   int n_err = 0;

   logic [MW-1:0] q0[$], q0w[$], q1[$], q2[$];
   logic          hold_prev [3] = '{1'b0, 1'b0, 1'b0};
   logic [MW-1:0] prev_bus  [3] = '{'0, '0, '0};

   always #5 clk = ~clk;

   gf_maxsum_conv #(.FIELD(3), .LLR_BIT(LB), .SATURATE(1'b1)) u_f3s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .llra(llra[11:0]), .llrb(llrb[11:0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .output_llr(o0));

   gf_maxsum_conv #(.FIELD(3), .LLR_BIT(LB), .SATURATE(1'b0)) u_f3w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[3]),
      .llra(llra[11:0]), .llrb(llrb[11:0]), .out_valid(out_valid[3]),
      .out_ready(out_ready[0]), .output_llr(o1));

   gf_maxsum_conv #(.FIELD(5), .LLR_BIT(LB), .SATURATE(1'b1)) u_f5 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .llra(llra[19:0]), .llrb(llrb[19:0]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .output_llr(o2));

   gf_maxsum_conv #(.FIELD(7), .LLR_BIT(LB), .SATURATE(1'b1)) u_f7 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .llra(llra), .llrb(llrb), .out_valid(out_valid[2]),
      .out_ready(out_ready[2]), .output_llr(o3));

   task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [MW-1:0] bus(input int c);
      case (c)
         0:       return {16'b0, o0};
         1:       return {8'b0, o2};
         2:       return o3;
         default: return {16'b0, o1};
      endcase
   endfunction

   function automatic int fld(input int c);
      return (c == 0) ? 3 : (c == 1) ? 5 : 7;
   endfunction

   function automatic int qsize(input int c);
      case (c)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic logic [MW-1:0] pk(input int e0, input int e1, input int e2,
                                        input int e3 = 0, input int e4 = 0,
                                        input int e5 = 0, input int e6 = 0);
      int            v [7];
      logic [MW-1:0] r;
      v = '{e0, e1, e2, e3, e4, e5, e6};
      r = '0;
      for (int i = 0; i < 7; i++) r[i*LB +: LB] = 4'(v[i]);
      return r;
   endfunction

   function automatic int sx(input logic [MW-1:0] x, input int i);
      logic signed [LB-1:0] t;
      t = x[i*LB +: LB];
      return int'(t);
   endfunction

   // reference: brute-force max over all i, then normalise and clamp/wrap
   function automatic logic [MW-1:0] model(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                           input int f, input bit sat);
      int            best [7];
      int            v, d;
      logic [MW-1:0] r;
      r = '0;
      for (int k = 0; k < f; k++) begin
         best[k] = -1000;
         for (int i = 0; i < f; i++) begin
            v = sx(a, i) + sx(b, (k - i + f) % f);
            if (v > best[k]) best[k] = v;
         end
      end
      for (int k = 0; k < f; k++) begin
         d = best[k] - best[0];
         if (sat) begin
            if (d < -8) d = -8;
            if (d > 7)  d = 7;
         end else begin
            d = ((d % 16) + 16) % 16;
            if (d > 7) d = d - 16;
         end
         r[k*LB +: LB] = 4'(d);
      end
      return r;
   endfunction

   // scoreboard check on every handshake, plus hold-stability under back-pressure
   always @(negedge clk) begin
      for (int c = 0; c < 3; c++) begin
         if (rst_n && hold_prev[c]) begin
            chk("hold_valid", {27'b0, out_valid[c]}, 1);
            chk("hold_data", bus(c), prev_bus[c]);
         end
         hold_prev[c] = rst_n && out_valid[c] && !out_ready[c];
         prev_bus[c]  = bus(c);
         if (rst_n && out_valid[c] && out_ready[c]) begin
            if (qsize(c) == 0) begin
               chk("unexpected_output", {27'b0, out_valid[c]}, 0);
            end else begin
               case (c)
                  0: begin
                     chk("res_f3_sat", bus(0), q0.pop_front());
                     chk("res_f3_wrap_valid", {27'b0, out_valid[3]}, 1);
                     chk("res_f3_wrap", bus(3), q0w.pop_front());
                  end
                  1:       chk("res_f5", bus(1), q1.pop_front());
                  default: chk("res_f7", bus(2), q2.pop_front());
               endcase
            end
         end
      end
   end

   // drive a pair until accepted; w = cycles spent waiting for in_ready
   task automatic send(input int c, input logic [MW-1:0] a, input logic [MW-1:0] b,
                       input logic [MW-1:0] e, input logic [MW-1:0] ew, output int w);
      bit got;
      got = 1'b0;
      w   = 0;
      llra = a;
      llrb = b;
      in_valid[c] = 1'b1;
      while (!got && w < 200) begin
         @(negedge clk);
         if (in_ready[c]) begin
            got = 1'b1;
            case (c)
               0: begin q0.push_back(e); q0w.push_back(ew); end
               1:       q1.push_back(e);
               default: q2.push_back(e);
            endcase
         end else begin
            w++;
         end
         @(posedge clk);
         #1;
      end
      in_valid[c] = 1'b0;
      if (!got) chk("accept_timeout", 0, 1);
   endtask

   // cycles from the accept edge until out_valid appears; accept cycle is cycle 0
   task automatic count_latency(input int c, input string tag, input int exp_cyc);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 50) begin
         @(negedge clk);
         if (out_valid[c]) seen = 1'b1;
         else begin
            @(posedge clk);
            n++;
         end
      end
      chk(tag, n + 1, exp_cyc);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input int c);
      int n;
      n = 0;
      while (qsize(c) != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      if (qsize(c) != 0) chk("drain_timeout", qsize(c), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic run_random(input int c, input int npairs);
      bit done;
      int f;
      done = 1'b0;
      f    = fld(c);
      fork
         begin
            logic [MW-1:0] a, b;
            int w;
            for (int p = 0; p < npairs; p++) begin
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
               a = MW'({$urandom, $urandom});
               b = MW'({$urandom, $urandom});
               send(c, a, b, model(a, b, f, 1'b1), model(a, b, f, 1'b0), w);
            end
            done = 1'b1;
         end
         begin
            int cyc;
            cyc = 0;
            while ((!done || qsize(c) != 0) && cyc < 20000) begin
               @(posedge clk);
               #1;
               out_ready[c] = ($urandom_range(0, 3) != 0);
               cyc++;
            end
            if (cyc >= 20000) chk("random_timeout", qsize(c), 0);
            out_ready[c] = 1'b1;
         end
      join
      wait_drain(c);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [MW-1:0] a1, b1, e1, a2, b2, e2s, e2w, a3, b3, e3, snap;
      int w, n, vcnt;

      a1  = pk(0, -2, -5);        b1 = pk(0, -1, -3);  e1 = pk(0, -1, -3);
      a2  = pk(-8, 7, -8);        b2 = pk(-8, -8, 7);
      e2s = pk(0, -8, -8);        e2w = pk(0, 1, 1);
      a3  = pk(0, -1, -2, -3, -4); b3 = pk(0, -8, -8, -8, -8);
      e3  = pk(0, -1, -2, -3, -4);

      rst_n = 1'b0;
      llra  = '0;
      llrb  = '0;
      for (int c = 0; c < 3; c++) begin
         in_valid[c]  = 1'b0;
         out_ready[c] = 1'b1;
      end
      #1;
      chk("rst_in_ready", {27'b0, in_ready[0]}, 1);
      chk("rst_out_valid", {27'b0, out_valid[0]}, 0);
      chk("rst_out_llr", bus(0), 0);
      chk("rst_out_llr_f7", bus(2), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // basic GF(3) result and latency
      send(0, a1, b1, e1, e1, w);
      count_latency(0, "latency_f3", 4);
      wait_drain(0);

      // saturation vs wrap
      send(0, a2, b2, e2s, e2w, w);
      wait_drain(0);

      // GF(5) modular indexing and latency
      send(1, a3, b3, e3, e3, w);
      count_latency(1, "latency_f5", 6);
      wait_drain(1);

      // back-pressure: result held for 10 cycles, then back-to-back accept
      out_ready[0] = 1'b0;
      send(0, a1, b1, e1, e1, w);
      n = 0;
      while (!out_valid[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      snap = bus(0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_out_valid", {27'b0, out_valid[0]}, 1);
         chk("bp_in_ready", {27'b0, in_ready[0]}, 0);
         chk("bp_out_llr", bus(0), snap);
      end
      @(posedge clk);
      #1;
      out_ready[0] = 1'b1;
      send(0, a2, b2, e2s, e2w, w);
      chk("b2b_same_cycle", w, 0);
      count_latency(0, "b2b_period", 4);
      wait_drain(0);

      // reset during COMP step 1 discards the pair
      send(0, a1, b1, e1, e1, w);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", {27'b0, in_ready[0]}, 1);
      chk("mid_rst_out_valid", {27'b0, out_valid[0]}, 0);
      chk("mid_rst_out_llr", bus(0), 0);
      chk("mid_rst_out_llr_wrap", bus(3), 0);
      void'(q0.pop_back());
      void'(q0w.pop_back());
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      vcnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid[0]) vcnt++;
      end
      chk("abort_no_valid", vcnt, 0);
      @(posedge clk);
      #1;
      send(0, a2, b2, e2s, e2w, w);
      wait_drain(0);

      // random traffic with stalls on each field size
      for (int c = 0; c < 3; c++) run_random(c, 300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
